// File: rtl/mau_pkg.sv
// mau_pkg: shared types and helpers for the memory access unit
package mau_pkg;
   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILLEGAL} mem_size_t;
   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} mau_state_t;
   function automatic logic is_aligned(input mem_size_t size, input logic [1:0] addr);
      return size == SZ_BYTE || (size == SZ_HALF && !addr[0]) || (size == SZ_WORD && addr == 2'b00);
   endfunction
endpackage

// File: rtl/mau_lane_align.sv
// mau_lane_align: little-endian lane extract/extend for loads and lane merge for stores
module mau_lane_align
   import mau_pkg::*;
#(
   parameter int DATA_W = 32,
   localparam int OW = $clog2(DATA_W / 8)
) (
   input  logic [DATA_W-1:0] word,
   input  logic [OW-1:0]     offset,
   input  mem_size_t         size,
   input  logic              sgn,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] ext,
   output logic [DATA_W-1:0] merged
);
   logic [DATA_W-1:0] sh;
   logic [DATA_W-1:0] mask;
   // shift the addressed lanes down for loads, and up under a lane mask for stores
   always_comb begin
      sh = word >> {offset, 3'b000};
      ext = size == SZ_BYTE ? (sgn ? DATA_W'($signed(sh[7:0])) : DATA_W'(sh[7:0])) :
            size == SZ_HALF ? (sgn ? DATA_W'($signed(sh[15:0])) : DATA_W'(sh[15:0])) :
                              (sgn ? DATA_W'($signed(sh[31:0])) : DATA_W'(sh[31:0]));
      mask = (size == SZ_BYTE ? DATA_W'(8'hFF) : size == SZ_HALF ? DATA_W'(16'hFFFF) :
              DATA_W'(32'hFFFF_FFFF)) << {offset, 3'b000};
      merged = (word & ~mask) | ((wdata << {offset, 3'b000}) & mask);
   end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store unit with RMW, read latency and misalignment detection
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int MEM_RD_LAT = 1
) (
   input  logic              clk_100M,
   input  logic              rst,
   input  logic              clk_en,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] w_data,
   output logic              wr_en,
   input  logic [DATA_W-1:0] r_data
);
   localparam int OW = $clog2(DATA_W / 8);
   localparam int CW = $clog2(MEM_RD_LAT) + 1;
   mau_state_t state;
   logic [CW-1:0] cnt;
   logic wr_q, sgn_q;
   mem_size_t size_q, req_sz;
   logic [OW-1:0] off_q;
   logic [DATA_W-1:0] wdata_q, ext, merged;
   assign req_sz = mem_size_t'(req_size);
   assign req_ready = state == IDLE;
   mau_lane_align #(.DATA_W(DATA_W)) u_align (
      .word(r_data), .offset(off_q), .size(size_q), .sgn(sgn_q),
      .wdata(wdata_q), .ext(ext), .merged(merged)
   );
   // request FSM with registered memory and response outputs; everything holds while clk_en is low
   always_ff @(posedge clk_100M) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         rsp_valid <= 1'b0;
         rsp_err <= 1'b0;
         rsp_rdata <= '0;
         mem_addr <= '0;
         w_data <= '0;
         wr_en <= 1'b0;
      end else if (clk_en) begin
         rsp_valid <= 1'b0;
         wr_en <= 1'b0;
         case (state)
            IDLE: if (req_valid) begin
               wr_q <= req_wr;
               size_q <= req_sz;
               sgn_q <= req_signed;
               off_q <= req_addr[OW-1:0];
               wdata_q <= req_wdata;
               if (!is_aligned(req_sz, req_addr[1:0])) begin
                  state <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err <= 1'b1;
               end else begin
                  rsp_err <= 1'b0;
                  mem_addr <= {req_addr[ADDR_W-1:OW], OW'(0)};
                  if (req_wr && req_sz == SZ_WORD && DATA_W == 32) begin
                     state <= WRITE;
                     wr_en <= 1'b1;
                     w_data <= req_wdata;
                  end else begin
                     state <= READ;
                     cnt <= CW'(MEM_RD_LAT - 1);
                  end
               end
            end
            READ: if (cnt == '0) begin
               if (wr_q) begin
                  state <= WRITE;
                  wr_en <= 1'b1;
                  w_data <= merged;
               end else begin
                  state <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= ext;
               end
            end else cnt <= cnt - 1'b1;
            WRITE: begin
               state <= RESP;
               rsp_valid <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of loads, RMW stores, errors, stalls and reset
module tb_mem_access_unit;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1, ce1 = 1'b1, ce3 = 1'b1, rv1 = 1'b0, rv3 = 1'b0;
   logic wr = 1'b0, sg = 1'b0;
   logic [1:0] sz = 2'b00;
   logic [31:0] addr = '0, wd = '0;

   logic rdy1, rsp_valid1, rsp_err1, wr_en1;
   logic [31:0] rsp_rdata1, mem_addr1, w_data1, r_data1;
   logic rdy3, rsp_valid3, rsp_err3, wr_en3;
   logic [31:0] rsp_rdata3, mem_addr3, w_data3, r_data3;

   mem_access_unit #(.MEM_RD_LAT(1)) dut1 (
      .clk_100M(clk), .rst(rst), .clk_en(ce1), .req_valid(rv1), .req_ready(rdy1),
      .req_wr(wr), .req_size(sz), .req_signed(sg), .req_addr(addr), .req_wdata(wd),
      .rsp_valid(rsp_valid1), .rsp_err(rsp_err1), .rsp_rdata(rsp_rdata1),
      .mem_addr(mem_addr1), .w_data(w_data1), .wr_en(wr_en1), .r_data(r_data1)
   );
   mem_access_unit #(.MEM_RD_LAT(3)) dut3 (
      .clk_100M(clk), .rst(rst), .clk_en(ce3), .req_valid(rv3), .req_ready(rdy3),
      .req_wr(wr), .req_size(sz), .req_signed(sg), .req_addr(addr), .req_wdata(wd),
      .rsp_valid(rsp_valid3), .rsp_err(rsp_err3), .rsp_rdata(rsp_rdata3),
      .mem_addr(mem_addr3), .w_data(w_data3), .wr_en(wr_en3), .r_data(r_data3)
   );

   // word memories: dut1 reads asynchronously, dut3 through two enabled pipeline stages
   logic [31:0] mem1 [16];
   logic [31:0] mem3 [16];
   logic [31:0] p0, p1;
   assign r_data1 = mem1[mem_addr1[5:2]];
   assign r_data3 = p1;
   always @(posedge clk) begin
      if (rst) begin
         mem1[0] <= 32'h8899AABB;
         mem1[1] <= 32'h0;
      end else if (ce1 && wr_en1) mem1[mem_addr1[5:2]] <= w_data1;
   end
   always @(posedge clk) begin
      if (rst) mem3[0] <= 32'h8899AABB;
      else if (ce3) begin
         if (wr_en3) mem3[mem_addr3[5:2]] <= w_data3;
         p0 <= mem3[mem_addr3[5:2]];
         p1 <= p0;
      end
   end

   int n_chk = 0, n_pass = 0;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   int rsp_at, wr_at, wr_n;
   logic [31:0] wr_addr, wr_dat, rd_addr, rd_val;
   logic err_val;

   // issue one request to dut1 and record when responses/writes appear, cycles counted from accept
   task automatic run1(input logic w, input logic [1:0] s, input logic g, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      wr = w; sz = s; sg = g; addr = a; wd = d; rv1 = 1'b1;
      @(posedge clk);
      rsp_at = -1; wr_at = -1; wr_n = 0; rd_val = 'x; err_val = 1'bx;
      for (int c = 1; c <= 10 && rsp_at < 0; c++) begin
         @(negedge clk);
         rv1 = 1'b0;
         if (c == 1) rd_addr = mem_addr1;
         if (wr_en1) begin wr_n++; wr_at = c; wr_addr = mem_addr1; wr_dat = w_data1; end
         if (rsp_valid1) begin rsp_at = c; rd_val = rsp_rdata1; err_val = rsp_err1; end
         if (rsp_at < 0) @(posedge clk);
      end
      @(posedge clk);
      @(negedge clk);
      chk("pulse_end", {rsp_valid1, rdy1}, 2'b01);
   endtask

   logic [8:1] hist;
   logic [31:0] rd3;

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ctrl", {rdy1, rsp_valid1, rsp_err1, wr_en1, rdy3, rsp_valid3}, 6'b100010);
      chk("rst_data", {rsp_rdata1, mem_addr1}, 64'h0);
      chk("rst_wdata", w_data1, 32'h0);
      rst = 1'b0;

      run1(1'b0, 2'b00, 1'b1, 32'h10010001, 32'h0);
      chk("lb_s_data", rd_val, 32'hFFFFFFAA);
      chk("lb_s_time", rsp_at, 2);
      chk("lb_s_nowr", wr_n, 0);
      chk("lb_s_addr", rd_addr, 32'h10010000);
      run1(1'b0, 2'b01, 1'b0, 32'h10010002, 32'h0);
      chk("lh_u_data", {err_val, rd_val}, {1'b0, 32'h00008899});
      chk("lh_u_time", rsp_at, 2);
      run1(1'b0, 2'b01, 1'b1, 32'h10010002, 32'h0);
      chk("lh_s_data", rd_val, 32'hFFFF8899);
      run1(1'b0, 2'b00, 1'b0, 32'h10010003, 32'h0);
      chk("lb_u_data", rd_val, 32'h00000088);
      run1(1'b0, 2'b10, 1'b1, 32'h10010000, 32'h0);
      chk("lw_data", rd_val, 32'h8899AABB);

      run1(1'b1, 2'b00, 1'b0, 32'h10010003, 32'h00000011);
      chk("sb_wr", {wr_n, wr_at}, {32'd1, 32'd2});
      chk("sb_addr", wr_addr, 32'h10010000);
      chk("sb_data", wr_dat, 32'h1199AABB);
      chk("sb_rsp", {err_val, rsp_at}, {1'b0, 32'd3});
      run1(1'b1, 2'b01, 1'b0, 32'h10010000, 32'h0000BEEF);
      chk("sh_data", wr_dat, 32'h1199BEEF);
      chk("sh_time", {wr_at, rsp_at}, {32'd2, 32'd3});
      run1(1'b1, 2'b10, 1'b0, 32'h10010004, 32'hCAFEF00D);
      chk("sw_wr", {wr_n, wr_at}, {32'd1, 32'd1});
      chk("sw_rsp", rsp_at, 2);
      chk("sw_addr_data", {wr_addr, wr_dat}, {32'h10010004, 32'hCAFEF00D});
      run1(1'b0, 2'b10, 1'b0, 32'h10010000, 32'h0);
      chk("rmw_mem", rd_val, 32'h1199BEEF);

      run1(1'b1, 2'b10, 1'b0, 32'h10010026, 32'h12345678);
      chk("mis_sw_err", {err_val, rsp_at, wr_n}, {1'b1, 32'd1, 32'd0});
      chk("mis_sw_noacc", rd_addr, 32'h10010000);
      run1(1'b0, 2'b11, 1'b0, 32'h10010004, 32'h0);
      chk("ill_err", {err_val, rsp_at, wr_n}, {1'b1, 32'd1, 32'd0});
      chk("ill_noacc", rd_addr, 32'h10010000);
      run1(1'b0, 2'b01, 1'b0, 32'h10010001, 32'h0);
      chk("mis_lh_err", {err_val, rsp_at}, {1'b1, 32'd1});
      run1(1'b0, 2'b10, 1'b0, 32'h10010004, 32'h0);
      chk("err_clear", {err_val, rd_val}, {1'b0, 32'hCAFEF00D});

      @(negedge clk);
      wr = 1'b1; sz = 2'b00; sg = 1'b0; addr = 32'h10010001; wd = 32'h55; rv1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rv1 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_mid_pre", wr_en1, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_post", {wr_en1, rdy1, rsp_valid1}, 3'b010);
      run1(1'b0, 2'b10, 1'b0, 32'h10010000, 32'h0);
      chk("rst_mid_load", {rd_val, rsp_at}, {32'h8899AABB, 32'd2});

      @(negedge clk);
      wr = 1'b0; sz = 2'b00; sg = 1'b1; addr = 32'h10010001; rv3 = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         rv3 = 1'b0;
         hist[c] = rsp_valid3;
         if (c == 6) rd3 = rsp_rdata3;
         ce3 = !(c == 2 || c == 3 || c == 6);
         if (c < 8) @(posedge clk);
      end
      chk("lat3_pulse", hist, 8'b0110_0000);
      chk("lat3_data", rd3, 32'hFFFFFFAA);
      chk("lat3_idle", {rdy3, rsp_err3, wr_en3}, 3'b100);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
